nonce_tx_arbiter: RTL and testbench

- Collects golden nonces from SLAVES hashing cores, all already synchronised into the comm clock domain.
- Holds one pending nonce per slave and grants the serial transmitter round-robin.
- Sequences the serial core's send/busy handshake, retrying on a stalled start.
- Replaces the single-slave hub logic and the ticket edge-detector that sit between sha256_top and serial_core.

---
 rtl/miner_pkg.sv | 14 +
 rtl/nonce_tx_arbiter_rr_pick.sv | 28 ++
 rtl/nonce_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_nonce_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared types for the nonce collection path between the hashing cores
// and the serial transmitter.
package miner_pkg;

   localparam int NONCE_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_BUSY,
      WAIT_DONE
   } tx_state_e;

endpackage

// File: rtl/nonce_tx_arbiter_rr_pick.sv
// Round-robin priority selector: first requester at or after ptr,
// wrapping modulo SLAVES.
module rr_pick #(
   parameter int SLAVES = 4
) (
   input  logic [SLAVES-1:0] req,
   input  logic [2:0]        ptr,
   output logic [2:0]        sel,
   output logic              any
);

   int idx;

   // Walk from the far end so the requester nearest ptr wins.
   always_comb begin
      any = 1'b0;
      sel = 3'd0;
      idx = 0;
      for (int k = SLAVES - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % SLAVES;
         if (req[idx]) begin
            any = 1'b1;
            sel = 3'(idx);
         end
      end
   end

endmodule

// File: rtl/nonce_tx_arbiter.sv
// Buffers one golden nonce per slave and feeds serial_core round-robin,
// re-pulsing tx_send when the transmitter fails to start.
module nonce_tx_arbiter
   import miner_pkg::*;
#(
   parameter int SLAVES        = 4,
   parameter int START_TIMEOUT = 64,
   parameter int DROP_BITS     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SLAVES-1:0]         nonce_valid,
   input  logic [NONCE_W*SLAVES-1:0] nonce_in,
   input  logic                      tx_busy,
   output logic                      tx_send,
   output logic [NONCE_W-1:0]        word,
   output logic [SLAVES-1:0]         pending,
   output logic [2:0]                grant_id,
   output logic [DROP_BITS-1:0]      drop_count,
   output logic                      nonce_found
);

   localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

   tx_state_e            state;
   logic [NONCE_W-1:0]   slot [SLAVES];
   logic [2:0]           rr_ptr;
   logic [CW-1:0]        cnt;

   logic [2:0]           sel;
   logic                 any;
   logic                 grant_en;
   logic [SLAVES-1:0]    gnt;
   logic [NONCE_W-1:0]   sel_word;
   logic [2:0]           next_ptr;
   logic [3:0]           drops;
   logic [DROP_BITS+3:0] dsum;

   rr_pick #(.SLAVES(SLAVES)) u_pick (
      .req (pending),
      .ptr (rr_ptr),
      .sel (sel),
      .any (any)
   );

   assign grant_en = (state == IDLE) && any && !tx_busy;
   assign next_ptr = (int'(sel) == SLAVES - 1) ? 3'd0 : sel + 3'd1;
   assign dsum = {4'd0, drop_count} + {{DROP_BITS{1'b0}}, drops};

   // A slot being granted this cycle can be refilled without loss.
   always_comb begin
      gnt      = '0;
      sel_word = '0;
      drops    = '0;
      for (int i = 0; i < SLAVES; i++) begin
         gnt[i] = grant_en && (sel == 3'(i));
         if (sel == 3'(i))
            sel_word = slot[i];
         if (nonce_valid[i] && pending[i] && !gnt[i])
            drops = drops + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= 3'd0;
         cnt         <= '0;
         tx_send     <= 1'b0;
         word        <= '0;
         pending     <= '0;
         grant_id    <= 3'd0;
         drop_count  <= '0;
         nonce_found <= 1'b0;
         for (int i = 0; i < SLAVES; i++)
            slot[i] <= '0;
      end else begin
         nonce_found <= |nonce_valid;
         pending     <= nonce_valid | (pending & ~gnt);
         for (int i = 0; i < SLAVES; i++)
            if (nonce_valid[i])
               slot[i] <= nonce_in[NONCE_W*i +: NONCE_W];

         if (|dsum[DROP_BITS+3:DROP_BITS])
            drop_count <= '1;
         else
            drop_count <= dsum[DROP_BITS-1:0];

         unique case (state)
            IDLE: begin
               if (grant_en) begin
                  word     <= sel_word;
                  grant_id <= sel;
                  rr_ptr   <= next_ptr;
                  tx_send  <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               tx_send <= 1'b0;
               cnt     <= '0;
               state   <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (cnt == CNT_LAST) begin
                  tx_send <= 1'b1;
                  state   <= SEND;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and a
// randomized run against a timeline-based reference model.
module tb_nonce_tx_arbiter;

   localparam int NS = 4;

   logic          clk;
   logic          rst;
   logic [NS-1:0] nonce_valid;
   logic [127:0]  nonce_in;
   logic          tx_busy;
   logic          tx_send;
   logic [31:0]   word;
   logic [NS-1:0] pending;
   logic [2:0]    grant_id;
   logic [7:0]    drop_count;
   logic          nonce_found;

   nonce_tx_arbiter #(
      .SLAVES(NS), .START_TIMEOUT(16), .DROP_BITS(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .nonce_valid (nonce_valid),
      .nonce_in    (nonce_in),
      .tx_busy     (tx_busy),
      .tx_send     (tx_send),
      .word        (word),
      .pending     (pending),
      .grant_id    (grant_id),
      .drop_count  (drop_count),
      .nonce_found (nonce_found)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   logic [31:0]   m_slot [NS];
   logic [NS-1:0] m_pend;
   int            m_drop, m_ptr, m_gid, m_since;
   logic [31:0]   m_word;
   bit            m_found, m_fly, m_seen, m_txs;

   // emulated serial core
   int bstart = -1;
   int brem = 0;
   logic [31:0] sent [$];

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic        busy;
      logic        txs;
      logic [31:0] w;
      logic [2:0]  gid;
      logic [3:0]  pend;
      logic [7:0]  drop;
      logic        found;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) m_slot[i] = '0;
      m_pend = '0; m_drop = 0; m_ptr = 0; m_gid = 0; m_since = 0;
      m_word = '0; m_found = 0; m_fly = 0; m_seen = 0; m_txs = 0;
      bstart = -1; brem = 0;
      sent.delete();
   endtask

   // One clock edge of the spec: grant from pre-edge state, then capture.
   task automatic model_edge();
      logic [NS-1:0] g;
      int drops;
      int idx;
      g = '0;
      drops = 0;
      if (!m_fly) begin
         if (m_pend != 0 && !tx_busy) begin
            idx = -1;
            for (int k = 0; k < NS; k++)
               if (idx < 0 && m_pend[(m_ptr + k) % NS])
                  idx = (m_ptr + k) % NS;
            g[idx] = 1'b1;
            m_word = m_slot[idx];
            m_gid = idx;
            m_ptr = (idx + 1) % NS;
            m_fly = 1; m_seen = 0; m_since = 0;
         end
      end else if (!m_seen) begin
         m_since++;
         if (m_since >= 2 && tx_busy) m_seen = 1;
         else if (m_since == 17) m_since = 0;
      end else if (!tx_busy) begin
         m_fly = 0;
      end
      m_txs = m_fly && !m_seen && (m_since == 0);
      for (int i = 0; i < NS; i++) begin
         if (nonce_valid[i] && m_pend[i] && !g[i]) drops++;
         if (nonce_valid[i]) m_slot[i] = nonce_in[32*i +: 32];
      end
      m_pend = nonce_valid | (m_pend & ~g);
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      m_found = |nonce_valid;
   endtask

   task automatic check_all();
      chk("tx_send", {31'd0, tx_send}, {31'd0, m_txs});
      chk("word", word, m_word);
      chk("grant_id", {29'd0, grant_id}, 32'(m_gid));
      chk("pending", {28'd0, pending}, {28'd0, m_pend});
      chk("drop_count", {24'd0, drop_count}, 32'(m_drop));
      chk("nonce_found", {31'd0, nonce_found}, {31'd0, m_found});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      nonce_valid = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nonce_valid = '0;
      tx_busy = 1'b0;
      model_reset();
      #20;
      check_all();
      rst = 1'b0;
   endtask

   task automatic run_auto(input int cycles, input bit rnd);
      for (int c = 0; c < cycles; c++) begin
         if (bstart == 0) begin
            brem = rnd ? int'($urandom_range(1, 8)) : 10;
            bstart = -1;
         end else if (bstart > 0) begin
            bstart--;
         end
         tx_busy = (brem > 0);
         if (brem > 0) brem--;
         if (rnd) begin
            for (int i = 0; i < NS; i++) begin
               nonce_valid[i] = ($urandom_range(0, 9) == 0);
               nonce_in[32*i +: 32] = $urandom;
            end
         end
         step();
         if (tx_send) begin
            sent.push_back(word);
            if (brem == 0 && bstart < 0 &&
                !(rnd && $urandom_range(0, 7) == 0))
               bstart = 1;
         end
      end
   endtask

   initial begin
      int pulses [$];
      int extra;

      clk = 1'b0;
      rst = 1'b1;
      nonce_valid = '0;
      nonce_in = '0;
      tx_busy = 1'b0;

      tbl[0]  = '{4'h4, 32'hDEADBEEF, 0, 0, 32'h0,        0, 4'h4, 0, 1};
      tbl[1]  = '{4'h0, 32'h0,        0, 1, 32'hDEADBEEF, 2, 4'h0, 0, 0};
      tbl[2]  = '{4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 2, 4'h0, 0, 0};
      tbl[3]  = '{4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 2, 4'h0, 0, 0};
      tbl[4]  = '{4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 2, 4'h0, 0, 0};
      tbl[5]  = '{4'h1, 32'h4,        0, 0, 32'hDEADBEEF, 2, 4'h1, 0, 1};
      tbl[6]  = '{4'h1, 32'h5,        0, 1, 32'h4,        0, 4'h1, 0, 1};
      tbl[7]  = '{4'h0, 32'h0,        0, 0, 32'h4,        0, 4'h1, 0, 0};
      tbl[8]  = '{4'h0, 32'h0,        1, 0, 32'h4,        0, 4'h1, 0, 0};
      tbl[9]  = '{4'h0, 32'h0,        0, 0, 32'h4,        0, 4'h1, 0, 0};
      tbl[10] = '{4'h0, 32'h0,        0, 1, 32'h5,        0, 4'h0, 0, 0};
      tbl[11] = '{4'h0, 32'h0,        0, 0, 32'h5,        0, 4'h0, 0, 0};
      tbl[12] = '{4'h0, 32'h0,        1, 0, 32'h5,        0, 4'h0, 0, 0};
      tbl[13] = '{4'h0, 32'h0,        0, 0, 32'h5,        0, 4'h0, 0, 0};

      do_reset();

      // single nonce latency, then same-cycle refill of a granted slot
      for (int r = 0; r < 14; r++) begin
         nonce_valid = tbl[r].v;
         nonce_in = {4{tbl[r].d}};
         tx_busy = tbl[r].busy;
         step();
         chk($sformatf("tbl%0d_tx_send", r), {31'd0, tx_send},
             {31'd0, tbl[r].txs});
         chk($sformatf("tbl%0d_word", r), word, tbl[r].w);
         chk($sformatf("tbl%0d_gid", r), {29'd0, grant_id},
             {29'd0, tbl[r].gid});
         chk($sformatf("tbl%0d_pend", r), {28'd0, pending},
             {28'd0, tbl[r].pend});
         chk($sformatf("tbl%0d_drop", r), {24'd0, drop_count},
             {24'd0, tbl[r].drop});
         chk($sformatf("tbl%0d_found", r), {31'd0, nonce_found},
             {31'd0, tbl[r].found});
      end

      // fairness
      do_reset();
      nonce_valid = 4'hF;
      nonce_in = {32'h13, 32'h12, 32'h11, 32'h10};
      run_auto(100, 0);
      chk("fair_count", sent.size(), 4);
      for (int k = 0; k < sent.size() && k < 4; k++)
         chk($sformatf("fair_word%0d", k), sent[k], 32'h10 + k);
      sent.delete();
      nonce_valid = 4'hA;
      nonce_in = {32'h23, 32'h0, 32'h21, 32'h0};
      run_auto(50, 0);
      chk("fair2_count", sent.size(), 2);
      if (sent.size() == 2) begin
         chk("fair2_first", sent[0], 32'h21);
         chk("fair2_second", sent[1], 32'h23);
      end

      // overwrite while blocked, then saturation
      do_reset();
      tx_busy = 1'b1;
      nonce_valid = 4'h2;
      nonce_in[63:32] = 32'hAAAA0001;
      step();
      nonce_valid = 4'h2;
      nonce_in[63:32] = 32'hAAAA0002;
      step();
      chk("ovw_drop", {24'd0, drop_count}, 32'd1);
      run_auto(40, 0);
      chk("ovw_count", sent.size(), 1);
      if (sent.size() == 1)
         chk("ovw_word", sent[0], 32'hAAAA0002);
      tx_busy = 1'b1;
      for (int k = 0; k < 301; k++) begin
         nonce_valid = 4'h2;
         nonce_in[63:32] = k;
         step();
      end
      chk("drop_sat", {24'd0, drop_count}, 32'd255);

      // start timeout: tx_busy never rises
      do_reset();
      nonce_valid = 4'h1;
      nonce_in[31:0] = 32'h77;
      for (int c = 0; c < 60; c++) begin
         step();
         if (tx_send) begin
            pulses.push_back(c);
            chk("tmo_word", word, 32'h77);
         end
      end
      chk("tmo_pulses", pulses.size(), 4);
      for (int k = 0; k < pulses.size(); k++)
         chk($sformatf("tmo_pulse%0d", k), pulses[k], 1 + 17 * k);
      tx_busy = 1'b1;
      repeat (3) step();
      tx_busy = 1'b0;
      extra = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (tx_send) extra++;
      end
      chk("tmo_no_extra", extra, 0);

      // async reset in WAIT_DONE with queued nonces
      do_reset();
      nonce_valid = 4'h7;
      nonce_in = {32'h33, 32'h32, 32'h31, 32'h30};
      step();
      step();
      step();
      tx_busy = 1'b1;
      step();
      step();
      chk("pre_rst_pend", {28'd0, pending}, 32'h6);
      #3 rst = 1'b1;
      #1;
      chk("rst_tx_send", {31'd0, tx_send}, 32'd0);
      chk("rst_word", word, 32'd0);
      chk("rst_pend", {28'd0, pending}, 32'd0);
      chk("rst_gid", {29'd0, grant_id}, 32'd0);
      chk("rst_drop", {24'd0, drop_count}, 32'd0);
      chk("rst_found", {31'd0, nonce_found}, 32'd0);
      model_reset();
      #3 rst = 1'b0;
      tx_busy = 1'b0;
      nonce_valid = 4'h8;
      nonce_in[127:96] = 32'h33;
      run_auto(30, 0);
      chk("post_rst_count", sent.size(), 1);
      if (sent.size() == 1)
         chk("post_rst_word", sent[0], 32'h33);
      chk("post_rst_gid", {29'd0, grant_id}, 32'd3);

      // randomized traffic against the model
      do_reset();
      run_auto(2000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
